id_ex_stage: RTL and testbench

- ID/EX pipeline register for the pipelined RV32I core.
- Captures the decoder control bundle together with ID-stage operands and carries them into EX.
- Detects load-use hazards and inserts bubbles; squashes wrong-path instructions when EX resolves a taken branch or jump.
- Exposes saturating stall and flush event counters for debug.

---
 rtl/id_ex_stage.sv | 105 ++++++++++
 tb/tb_id_ex_stage.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the pipelined RV32I core: carries the decoder bundle into EX,
// inserts load-use bubbles, squashes wrong-path instructions and counts stall/flush events.
module id_ex_stage #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [XLEN-1:0]  id_pc,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [4:0]       id_rd,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic [XLEN-1:0]  id_rd1,
   input  logic [XLEN-1:0]  id_rd2,
   input  logic [XLEN-1:0]  id_imm,
   input  logic             id_RegWrite,
   input  logic             id_MemWrite,
   input  logic             id_MemRead,
   input  logic             id_ALUSrc,
   input  logic [4:0]       id_ALUOp,
   input  logic [4:0]       id_NPCOp,
   input  logic [1:0]       id_WDSel,
   input  logic             ex_flush,
   output logic             stall,
   output logic             ex_valid,
   output logic [XLEN-1:0]  ex_pc,
   output logic [XLEN-1:0]  ex_rd1,
   output logic [XLEN-1:0]  ex_rd2,
   output logic [XLEN-1:0]  ex_imm,
   output logic [4:0]       ex_rs1,
   output logic [4:0]       ex_rs2,
   output logic [4:0]       ex_rd,
   output logic             ex_RegWrite,
   output logic             ex_MemWrite,
   output logic             ex_MemRead,
   output logic             ex_ALUSrc,
   output logic [4:0]       ex_ALUOp,
   output logic [4:0]       ex_NPCOp,
   output logic [1:0]       ex_WDSel,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   logic w_hz;
   logic w_bubble;

   // A load in EX whose destination is read by the ID instruction; x0 never forwards a hazard.
   assign w_hz = ex_valid & ex_MemRead & (ex_rd != 5'd0) & id_valid &
                 ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));

   assign stall    = w_hz & ~ex_flush & ~rst;
   assign w_bubble = rst | ex_flush | w_hz;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (w_bubble) begin
         ex_valid    <= 1'b0;
         ex_pc       <= '0;
         ex_rd1      <= '0;
         ex_rd2      <= '0;
         ex_imm      <= '0;
         ex_rs1      <= '0;
         ex_rs2      <= '0;
         ex_rd       <= '0;
         ex_RegWrite <= 1'b0;
         ex_MemWrite <= 1'b0;
         ex_MemRead  <= 1'b0;
         ex_ALUSrc   <= 1'b0;
         ex_ALUOp    <= '0;
         ex_NPCOp    <= '0;
         ex_WDSel    <= '0;
      end else begin
         ex_valid    <= id_valid;
         ex_pc       <= id_pc;
         ex_rd1      <= id_rd1;
         ex_rd2      <= id_rd2;
         ex_imm      <= id_imm;
         ex_rs1      <= id_rs1;
         ex_rs2      <= id_rs2;
         ex_rd       <= id_rd;
         // Controls of an invalid slot are forced to the bubble encoding so it never writes state.
         ex_RegWrite <= id_valid & id_RegWrite;
         ex_MemWrite <= id_valid & id_MemWrite;
         ex_MemRead  <= id_valid & id_MemRead;
         ex_ALUSrc   <= id_valid & id_ALUSrc;
         ex_ALUOp    <= id_valid ? id_ALUOp : 5'd0;
         ex_NPCOp    <= id_valid ? id_NPCOp : 5'd0;
         ex_WDSel    <= id_valid ? id_WDSel : 2'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
         if (ex_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a driver pushes hand-derived expectations per vector,
// a monitor samples stall mid-cycle and the EX outputs after each edge and compares.
module tb_id_ex_stage;

   localparam int XLEN  = 32;
   localparam int CNT_W = 2;

   typedef struct {
      logic        valid;
      logic [31:0] pc;
      logic [4:0]  rs1, rs2, rd;
      logic        u1, u2;
      logic [31:0] rd1, rd2, imm;
      logic        rw, mw, mr, as;
      logic [4:0]  aluop, npcop;
      logic [1:0]  wdsel;
   } instr_t;

   typedef struct {
      int          id;
      logic        stall;
      instr_t      f;
      logic [1:0]  scnt, fcnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic id_valid, id_uses_rs1, id_uses_rs2;
   logic [XLEN-1:0] id_pc, id_rd1, id_rd2, id_imm;
   logic [4:0] id_rs1, id_rs2, id_rd, id_ALUOp, id_NPCOp;
   logic id_RegWrite, id_MemWrite, id_MemRead, id_ALUSrc;
   logic [1:0] id_WDSel;
   logic ex_flush;
   logic stall, ex_valid;
   logic [XLEN-1:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
   logic [4:0] ex_rs1, ex_rs2, ex_rd, ex_ALUOp, ex_NPCOp;
   logic ex_RegWrite, ex_MemWrite, ex_MemRead, ex_ALUSrc;
   logic [1:0] ex_WDSel;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_vec   = 0;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
      .id_RegWrite(id_RegWrite), .id_MemWrite(id_MemWrite), .id_MemRead(id_MemRead),
      .id_ALUSrc(id_ALUSrc), .id_ALUOp(id_ALUOp), .id_NPCOp(id_NPCOp), .id_WDSel(id_WDSel),
      .ex_flush(ex_flush), .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
      .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_RegWrite(ex_RegWrite), .ex_MemWrite(ex_MemWrite), .ex_MemRead(ex_MemRead),
      .ex_ALUSrc(ex_ALUSrc), .ex_ALUOp(ex_ALUOp), .ex_NPCOp(ex_NPCOp), .ex_WDSel(ex_WDSel),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   task automatic check(input int id, input string nm, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL vec%0d %s: got %0h, expected %0h", id, nm, act, req);
      end
   endtask

   function automatic instr_t mk_add(input logic [31:0] pc, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2);
      instr_t i;
      i = '{valid: 1'b1, pc: pc, rs1: rs1, rs2: rs2, rd: rd, u1: 1'b1, u2: 1'b1,
            rd1: 32'hA000_0000 | 32'(rs1), rd2: 32'hB000_0000 | 32'(rs2), imm: 32'h0,
            rw: 1'b1, mw: 1'b0, mr: 1'b0, as: 1'b0, aluop: 5'd1, npcop: 5'd0, wdsel: 2'd0};
      return i;
   endfunction

   function automatic instr_t mk_lw(input logic [31:0] pc, input logic [4:0] rd, input logic [4:0] rs1);
      instr_t i;
      i = '{valid: 1'b1, pc: pc, rs1: rs1, rs2: 5'd0, rd: rd, u1: 1'b1, u2: 1'b0,
            rd1: 32'hC000_0000 | 32'(rs1), rd2: 32'h0, imm: 32'h0000_0004,
            rw: 1'b1, mw: 1'b0, mr: 1'b1, as: 1'b1, aluop: 5'd1, npcop: 5'd0, wdsel: 2'd1};
      return i;
   endfunction

   // lui x5 whose raw rs1/rs2 bit fields happen to equal 5 but which reads no register.
   function automatic instr_t mk_lui(input logic [31:0] pc, input logic [4:0] rd);
      instr_t i;
      i = '{valid: 1'b1, pc: pc, rs1: 5'd5, rs2: 5'd5, rd: rd, u1: 1'b0, u2: 1'b0,
            rd1: 32'h0, rd2: 32'h0, imm: 32'h1234_5000,
            rw: 1'b1, mw: 1'b0, mr: 1'b0, as: 1'b1, aluop: 5'd2, npcop: 5'd0, wdsel: 2'd0};
      return i;
   endfunction

   // Expected EX contents: the presented fields with controls zeroed for an invalid slot, or all zero.
   function automatic instr_t ex_of(input instr_t i, input bit loaded);
      instr_t e;
      e = '{valid: 1'b0, pc: '0, rs1: '0, rs2: '0, rd: '0, u1: 1'b0, u2: 1'b0,
            rd1: '0, rd2: '0, imm: '0, rw: 1'b0, mw: 1'b0, mr: 1'b0, as: 1'b0,
            aluop: '0, npcop: '0, wdsel: '0};
      if (loaded) begin
         e = i;
         if (!i.valid) begin
            e.rw = 1'b0; e.mw = 1'b0; e.mr = 1'b0; e.as = 1'b0;
            e.aluop = '0; e.npcop = '0; e.wdsel = '0;
         end
      end
      return e;
   endfunction

   task automatic step(input instr_t i, input logic flush, input logic r, input logic exp_stall,
                       input bit loaded, input logic [1:0] scnt, input logic [1:0] fcnt);
      exp_t e;
      @(negedge clk);
      rst = r; ex_flush = flush;
      id_valid = i.valid; id_pc = i.pc; id_rs1 = i.rs1; id_rs2 = i.rs2; id_rd = i.rd;
      id_uses_rs1 = i.u1; id_uses_rs2 = i.u2; id_rd1 = i.rd1; id_rd2 = i.rd2; id_imm = i.imm;
      id_RegWrite = i.rw; id_MemWrite = i.mw; id_MemRead = i.mr; id_ALUSrc = i.as;
      id_ALUOp = i.aluop; id_NPCOp = i.npcop; id_WDSel = i.wdsel;
      e.id = n_vec; e.stall = exp_stall; e.f = ex_of(i, loaded); e.scnt = scnt; e.fcnt = fcnt;
      sb_q.push_back(e);
      n_vec++;
   endtask

   // Monitor: stall is sampled mid-cycle with inputs settled, EX outputs just after the edge.
   initial begin
      logic s_stall;
      exp_t e;
      forever begin
         @(negedge clk);
         #3 s_stall = stall;
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.id, "stall",     64'(s_stall),     64'(e.stall));
            check(e.id, "ex_valid",  64'(ex_valid),    64'(e.f.valid));
            check(e.id, "ex_pc",     64'(ex_pc),       64'(e.f.pc));
            check(e.id, "ex_rd1",    64'(ex_rd1),      64'(e.f.rd1));
            check(e.id, "ex_rd2",    64'(ex_rd2),      64'(e.f.rd2));
            check(e.id, "ex_imm",    64'(ex_imm),      64'(e.f.imm));
            check(e.id, "ex_rs1",    64'(ex_rs1),      64'(e.f.rs1));
            check(e.id, "ex_rs2",    64'(ex_rs2),      64'(e.f.rs2));
            check(e.id, "ex_rd",     64'(ex_rd),       64'(e.f.rd));
            check(e.id, "RegWrite",  64'(ex_RegWrite), 64'(e.f.rw));
            check(e.id, "MemWrite",  64'(ex_MemWrite), 64'(e.f.mw));
            check(e.id, "MemRead",   64'(ex_MemRead),  64'(e.f.mr));
            check(e.id, "ALUSrc",    64'(ex_ALUSrc),   64'(e.f.as));
            check(e.id, "ALUOp",     64'(ex_ALUOp),    64'(e.f.aluop));
            check(e.id, "NPCOp",     64'(ex_NPCOp),    64'(e.f.npcop));
            check(e.id, "WDSel",     64'(ex_WDSel),    64'(e.f.wdsel));
            check(e.id, "stall_cnt", 64'(stall_cnt),   64'(e.scnt));
            check(e.id, "flush_cnt", 64'(flush_cnt),   64'(e.fcnt));
         end
      end
   end

   initial begin
      instr_t inv;
      rst = 1'b1; ex_flush = 1'b0; id_valid = 1'b0; id_pc = '0; id_rs1 = '0; id_rs2 = '0;
      id_rd = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_rd1 = '0; id_rd2 = '0; id_imm = '0;
      id_RegWrite = 1'b0; id_MemWrite = 1'b0; id_MemRead = 1'b0; id_ALUSrc = 1'b0;
      id_ALUOp = '0; id_NPCOp = '0; id_WDSel = '0;

      //   instruction                        flush rst  stall loaded scnt fcnt
      step(mk_add(32'h10, 5'd3, 5'd1, 5'd2),  1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0); // reset
      step(mk_add(32'h10, 5'd3, 5'd1, 5'd2),  1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0); // straight-line
      step(mk_lw (32'h14, 5'd5, 5'd1),        1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0);
      step(mk_add(32'h18, 5'd6, 5'd5, 5'd7),  1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 2'd0); // load-use bubble
      step(mk_add(32'h18, 5'd6, 5'd5, 5'd7),  1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0); // re-presented add
      step(mk_lw (32'h1c, 5'd0, 5'd1),        1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0); // lw x0
      step(mk_add(32'h20, 5'd8, 5'd0, 5'd0),  1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0); // reads x0: no stall
      step(mk_lw (32'h24, 5'd5, 5'd1),        1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0);
      step(mk_lui(32'h28, 5'd5),              1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0); // lui: no reads
      step(mk_lw (32'h2c, 5'd5, 5'd1),        1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0);
      step(mk_add(32'h30, 5'd6, 5'd5, 5'd7),  1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1); // flush beats hazard
      inv = mk_add(32'h34, 5'd9, 5'd2, 5'd4);
      inv.valid = 1'b0;
      step(inv,                               1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd1); // invalid slot
      // Four more load-use pairs: stall_cnt reaches 3 and then holds.
      step(mk_lw (32'h40, 5'd5, 5'd1),        1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd1);
      step(mk_add(32'h44, 5'd6, 5'd7, 5'd5),  1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 2'd1);
      step(mk_lw (32'h48, 5'd5, 5'd1),        1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd1);
      step(mk_add(32'h4c, 5'd6, 5'd7, 5'd5),  1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 2'd1);
      step(mk_lw (32'h50, 5'd5, 5'd1),        1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 2'd1);
      step(mk_add(32'h54, 5'd6, 5'd7, 5'd5),  1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 2'd1);
      step(mk_lw (32'h58, 5'd5, 5'd1),        1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 2'd1);
      step(mk_add(32'h5c, 5'd6, 5'd7, 5'd5),  1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 2'd1);
      // Reset arriving while a load-use hazard is present.
      step(mk_lw (32'h60, 5'd5, 5'd1),        1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 2'd1);
      step(mk_add(32'h64, 5'd6, 5'd5, 5'd7),  1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
      step(mk_add(32'h68, 5'd3, 5'd1, 5'd2),  1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0);
      step(mk_add(32'h6c, 5'd4, 5'd1, 5'd2),  1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1); // plain flush

      @(negedge clk);
      rst = 1'b0; ex_flush = 1'b0; id_valid = 1'b0;
      for (int k = 0; k < 10 && sb_q.size() != 0; k++) @(negedge clk);
      if (sb_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
